// File: rtl/instruction_fetch_unit_pkg.sv
// Shared widths, pc_sel encodings and FSM state codes for the instruction fetch unit.
package ifu_pkg;

  localparam int INSTR_W = 32;
  localparam int ADDR_W  = 64;

  localparam logic [1:0] PC_HOLD = 2'b00;
  localparam logic [1:0] PC_INC  = 2'b01;
  localparam logic [1:0] PC_REL  = 2'b10;
  localparam logic [1:0] PC_ABS  = 2'b11;

  typedef logic [1:0] state_t;
  localparam state_t FETCH   = 2'd0;
  localparam state_t EXECUTE = 2'd1;
  localparam state_t DRAIN   = 2'd2;

endpackage

// File: rtl/instruction_fetch_unit_pc_next.sv
// Combinational next-PC: hold, +4, signed word-relative branch, or word-aligned absolute.
module ifu_pc_next
  import ifu_pkg::*;
(
  input  logic [ADDR_W-1:0] pc,
  input  logic [1:0]        pc_sel,
  input  logic [ADDR_W-1:0] constant,
  output logic [ADDR_W-1:0] next_pc
);

  logic signed [ADDR_W-1:0] offset;

  // Offsets are in words; the sum wraps modulo 2^64.
  always_comb begin
    offset  = $signed(constant) <<< 2;
    next_pc = pc;
    case (pc_sel)
      PC_INC:  next_pc = pc + ADDR_W'(4);
      PC_REL:  next_pc = pc + $unsigned(offset);
      PC_ABS:  next_pc = {constant[ADDR_W-1:2], 2'b00};
      default: next_pc = pc;
    endcase
  end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch front end: PC, req/ack fetch FSM and instruction hold for the multicycle control unit.
// Define IFU_PREFETCH_EN to add the one-entry next-word prefetch buffer and the DRAIN state.
module instruction_fetch_unit
  import ifu_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = 64'h0
) (
  input  logic               clock,
  input  logic               reset,
  output logic               mem_req,
  output logic [ADDR_W-1:0]  mem_addr,
  input  logic               mem_ack,
  input  logic [INSTR_W-1:0] mem_rdata,
  output logic [INSTR_W-1:0] instruction,
  output logic               instr_valid,
  output logic [ADDR_W-1:0]  pc,
  input  logic               pc_load,
  input  logic [1:0]         pc_sel,
  input  logic [ADDR_W-1:0]  constant
);

  state_t            state;
  logic [ADDR_W-1:0] pc_next;

  ifu_pc_next u_pc_next (
    .pc       (pc),
    .pc_sel   (pc_sel),
    .constant (constant),
    .next_pc  (pc_next)
  );

`ifdef IFU_PREFETCH_EN
  logic [INSTR_W-1:0] pf_buf;
  logic               pf_valid;
  logic               pf_busy;
  logic [ADDR_W-1:0]  pc_plus4;

  ifu_pc_next u_pf_addr (
    .pc       (pc),
    .pc_sel   (PC_INC),
    .constant ('0),
    .next_pc  (pc_plus4)
  );

  // Any request outstanding while executing is the prefetch of pc+4.
  assign pf_busy = mem_req && (state == EXECUTE);

  always_ff @(posedge clock) begin
    if (pf_busy && mem_ack) pf_buf <= mem_rdata;
  end
`endif

  always_ff @(posedge clock) begin
    if (!reset) begin
      state       <= FETCH;
      pc          <= RESET_PC;
      mem_req     <= 1'b0;
      mem_addr    <= RESET_PC;
      instruction <= '0;
      instr_valid <= 1'b0;
`ifdef IFU_PREFETCH_EN
      pf_valid    <= 1'b0;
`endif
    end else begin
      case (state)
        FETCH: begin
          if (!mem_req) begin
            mem_req  <= 1'b1;
            mem_addr <= pc;
          end else if (mem_ack) begin
            instruction <= mem_rdata;
            instr_valid <= 1'b1;
            mem_req     <= 1'b0;
            state       <= EXECUTE;
          end
        end
        EXECUTE: begin
`ifdef IFU_PREFETCH_EN
          if (pc_load && (pc_sel == PC_INC) && (pf_valid || (pf_busy && mem_ack))) begin
            // Zero-bubble advance: the next word is already here.
            instruction <= pf_valid ? pf_buf : mem_rdata;
            pc          <= pc_next;
            pf_valid    <= 1'b0;
            mem_req     <= 1'b0;
          end else if (pc_load && (pc_sel != PC_HOLD)) begin
            pc          <= pc_next;
            instr_valid <= 1'b0;
            pf_valid    <= 1'b0;
            mem_req     <= 1'b1;
            state       <= FETCH;
            if (pf_busy && !mem_ack) begin
              // Sequential: the in-flight prefetch already targets the new pc.
              // Taken: the stale request must complete before the target goes out.
              if (pc_sel != PC_INC) state <= DRAIN;
            end else begin
              mem_addr <= pc_next;
            end
          end else if (pf_busy && mem_ack) begin
            pf_valid <= 1'b1;
            mem_req  <= 1'b0;
          end else if (!pf_busy && !pf_valid) begin
            mem_req  <= 1'b1;
            mem_addr <= pc_plus4;
          end
`else
          if (pc_load && (pc_sel != PC_HOLD)) begin
            pc          <= pc_next;
            instr_valid <= 1'b0;
            mem_req     <= 1'b1;
            mem_addr    <= pc_next;
            state       <= FETCH;
          end
`endif
        end
`ifdef IFU_PREFETCH_EN
        DRAIN: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            state   <= FETCH;
          end
        end
`endif
        default: state <= FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit with a latency-programmable memory responder.
module tb_instruction_fetch_unit;
  import ifu_pkg::*;

  logic               clock = 1'b0;
  logic               reset;
  logic               mem_req;
  logic [ADDR_W-1:0]  mem_addr;
  logic               mem_ack;
  logic [INSTR_W-1:0] mem_rdata;
  logic [INSTR_W-1:0] instruction;
  logic               instr_valid;
  logic [ADDR_W-1:0]  pc;
  logic               pc_load;
  logic [1:0]         pc_sel;
  logic [ADDR_W-1:0]  constant;

  logic               mem_auto = 1'b1;
  logic               auto_ack = 1'b0;
  logic [INSTR_W-1:0] auto_rdata = '0;
  logic               man_ack = 1'b0;
  logic [INSTR_W-1:0] man_rdata = '0;
  int                 lat = 2;
  int                 n_vec = 0;
  int                 n_err = 0;
  int                 k;

  assign mem_ack   = mem_auto ? auto_ack   : man_ack;
  assign mem_rdata = mem_auto ? auto_rdata : man_rdata;

  instruction_fetch_unit #(.RESET_PC(64'h0)) dut (
    .clock       (clock),
    .reset       (reset),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_ack     (mem_ack),
    .mem_rdata   (mem_rdata),
    .instruction (instruction),
    .instr_valid (instr_valid),
    .pc          (pc),
    .pc_load     (pc_load),
    .pc_sel      (pc_sel),
    .constant    (constant)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] word_at(input logic [63:0] a);
    return (a == 64'h0) ? 32'h8B02_0020 : (a[31:0] ^ 32'h5A5A_0000);
  endfunction

  // Memory: acks lat negedges after seeing a request, holding ack over exactly one posedge.
  initial begin
    int wcnt;
    wcnt = 0;
    forever begin
      @(negedge clock);
      if (!reset || !mem_req) begin
        auto_ack = 1'b0;
        wcnt     = 0;
      end else if (auto_ack) begin
        auto_ack = 1'b0;
        wcnt     = 0;
      end else if (wcnt >= lat) begin
        auto_ack   = 1'b1;
        auto_rdata = word_at(mem_addr);
      end else begin
        wcnt++;
      end
    end
  end

  task automatic check_vec(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic wait_valid(input string tag, output int cycles);
    cycles = 0;
    while (!instr_valid && cycles < 40) begin
      @(negedge clock);
      cycles++;
    end
    pc_load = 1'b0;
    check_vec({tag, " valid"}, instr_valid, 1'b1);
  endtask

  // pc_load stays asserted (as an absolute jump) through FETCH to show it is ignored there.
  task automatic do_load(input logic [1:0] sel, input logic [63:0] c, input logic [63:0] exp,
                         input string tag);
    int cyc;
    pc_load  = 1'b1;
    pc_sel   = sel;
    constant = c;
    @(negedge clock);
    pc_sel   = PC_ABS;
    constant = 64'h700;
    check_vec({tag, " pc"}, pc, exp);
    check_vec({tag, " req"}, mem_req, 1'b1);
    check_vec({tag, " addr"}, mem_addr, exp);
    check_vec({tag, " bubble"}, instr_valid, 1'b0);
    wait_valid(tag, cyc);
    check_vec({tag, " instr"}, instruction, word_at(exp));
    check_vec({tag, " pc held"}, pc, exp);
  endtask

  initial begin
    reset    = 1'b0;
    pc_load  = 1'b0;
    pc_sel   = PC_HOLD;
    constant = '0;
    repeat (3) @(negedge clock);
    check_vec("rst req", mem_req, 1'b0);
    check_vec("rst pc", pc, 64'h0);
    check_vec("rst addr", mem_addr, 64'h0);
    check_vec("rst instr", instruction, 32'h0);
    check_vec("rst valid", instr_valid, 1'b0);

    reset = 1'b1;
    @(negedge clock);
    check_vec("first req", mem_req, 1'b1);
    check_vec("first addr", mem_addr, 64'h0);
    wait_valid("first", k);
    check_vec("first latency", k, 3);
    check_vec("first instr", instruction, 32'h8B02_0020);
    check_vec("first pc", pc, 64'h0);

`ifndef IFU_PREFETCH_EN
    pc_load = 1'b1;
    pc_sel  = PC_HOLD;
    @(negedge clock);
    pc_load = 1'b0;
    check_vec("hold valid", instr_valid, 1'b1);
    check_vec("hold pc", pc, 64'h0);
    check_vec("hold no fetch", mem_req, 1'b0);
    check_vec("hold instr", instruction, 32'h8B02_0020);

    mem_auto  = 1'b0;
    man_ack   = 1'b1;
    man_rdata = 32'hDEAD_BEEF;
    @(negedge clock);
    man_ack  = 1'b0;
    mem_auto = 1'b1;
    check_vec("stray ack instr", instruction, 32'h8B02_0020);
    check_vec("stray ack valid", instr_valid, 1'b1);

    do_load(PC_INC, 64'h0, 64'h4, "seq1");
    do_load(PC_INC, 64'h0, 64'h8, "seq2");
    do_load(PC_INC, 64'h0, 64'hC, "seq3");
    do_load(PC_ABS, 64'h100, 64'h100, "abs100");
    do_load(PC_REL, 64'hFFFF_FFFF_FFFF_FFFC, 64'hF0, "rel-4");
    do_load(PC_ABS, 64'h2003, 64'h2000, "abs2003");
    do_load(PC_ABS, 64'hFFFF_FFFF_FFFF_FFFC, 64'hFFFF_FFFF_FFFF_FFFC, "abstop");
    do_load(PC_INC, 64'h0, 64'h0, "wrap");
`else
    repeat (6) @(negedge clock);
    check_vec("pf idle after fill", mem_req, 1'b0);
    check_vec("pf instr kept", instruction, 32'h8B02_0020);

    pc_load = 1'b1;
    pc_sel  = PC_INC;
    @(negedge clock);
    pc_load = 1'b0;
    check_vec("pf seq valid held", instr_valid, 1'b1);
    check_vec("pf seq pc", pc, 64'h4);
    check_vec("pf seq instr", instruction, word_at(64'h4));
    @(negedge clock);
    check_vec("pf next req", mem_req, 1'b1);
    check_vec("pf next addr", mem_addr, 64'h8);

    pc_load  = 1'b1;
    pc_sel   = PC_REL;
    constant = 64'h4;
    @(negedge clock);
    pc_sel   = PC_ABS;
    constant = 64'h700;
    check_vec("drain pc", pc, 64'h14);
    check_vec("drain valid", instr_valid, 1'b0);
    check_vec("drain req", mem_req, 1'b1);
    check_vec("drain stale addr", mem_addr, 64'h8);
    wait_valid("drain", k);
    check_vec("drain target instr", instruction, word_at(64'h14));
    check_vec("drain ignore load pc", pc, 64'h14);
`endif

    pc_load = 1'b1;
    pc_sel  = PC_INC;
    @(negedge clock);
    pc_load = 1'b0;
    check_vec("midrst req before", mem_req, 1'b1);
    reset = 1'b0;
    @(negedge clock);
    check_vec("midrst req", mem_req, 1'b0);
    check_vec("midrst pc", pc, 64'h0);
    check_vec("midrst addr", mem_addr, 64'h0);
    check_vec("midrst valid", instr_valid, 1'b0);
    check_vec("midrst instr", instruction, 32'h0);
    reset = 1'b1;
    @(negedge clock);
    wait_valid("refetch", k);
    check_vec("refetch instr", instruction, 32'h8B02_0020);
    check_vec("refetch pc", pc, 64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
